// File: rtl/riscv_pkg.sv
// Shared types for the issue stage: register indices, ALU ops, issue-register payload and FSM states.
package riscv_pkg;

  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef enum logic [1:0] {ISSUE_RUN, ISSUE_HAZARD, ISSUE_DRAIN} issue_state_t;

  typedef struct packed {
    reg_addr_t   rs1;
    reg_addr_t   rs2;
    reg_addr_t   rd;
    logic        reg_write;
    logic        alu_src;
    alu_op_t     alu_op;
    logic [63:0] imm;
  } issue_op_t;

  // x0 is hardwired, so writes to it never create a pending entry.
  function automatic logic is_tracked(logic reg_write, reg_addr_t rd);
    return reg_write && (rd != '0);
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode-to-issue and issue-to-execute handshake bundle; master drives decode/execute side.
interface issue_ctrl_if;
  import riscv_pkg::*;

  logic        dec_valid_i;
  logic        dec_ready_o;
  reg_addr_t   dec_rs1_addr_i;
  reg_addr_t   dec_rs2_addr_i;
  reg_addr_t   dec_rd_addr_i;
  logic        dec_reg_write_i;
  logic        dec_alu_src_i;
  alu_op_t     dec_alu_op_i;
  logic [63:0] dec_imm_i;

  logic        ex_valid_o;
  logic        ex_ready_i;
  reg_addr_t   ex_rs1_addr_o;
  reg_addr_t   ex_rs2_addr_o;
  reg_addr_t   ex_rd_addr_o;
  logic        ex_reg_write_o;
  logic        ex_alu_src_o;
  alu_op_t     ex_alu_op_o;
  logic [63:0] ex_imm_o;

  modport master (
    output dec_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i, dec_reg_write_i,
           dec_alu_src_i, dec_alu_op_i, dec_imm_i, ex_ready_i,
    input  dec_ready_o, ex_valid_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
           ex_reg_write_o, ex_alu_src_o, ex_alu_op_o, ex_imm_o
  );

  modport slave (
    input  dec_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i, dec_reg_write_i,
           dec_alu_src_i, dec_alu_op_i, dec_imm_i, ex_ready_i,
    output dec_ready_o, ex_valid_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
           ex_reg_write_o, ex_alu_src_o, ex_alu_op_o, ex_imm_o
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Pending-write mask with set/clear ports and RAW/WAW hazard lookup.
// Optional ISSUE_WB_BYPASS_EN lets a same-cycle writeback hide its rd from the lookup.
module issue_scoreboard
  import riscv_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 set_en_i,
  input  reg_addr_t            set_addr_i,
  input  logic                 clr_en_i,
  input  reg_addr_t            clr_addr_i,
  input  logic                 valid_i,
  input  reg_addr_t            rs1_i,
  input  reg_addr_t            rs2_i,
  input  reg_addr_t            rd_i,
  input  logic                 use_rs2_i,
  input  logic                 chk_rd_i,
  output logic                 hazard_o,
  output logic [REG_COUNT-1:0] pending_o
);

  logic [REG_COUNT-1:0] pending_q, pending_d;
  logic [REG_COUNT-1:0] set_mask, clr_mask, lookup;

  always_comb begin
    set_mask  = set_en_i ? ((REG_COUNT'(1) << set_addr_i) & ~REG_COUNT'(1)) : '0;
    clr_mask  = clr_en_i ? (REG_COUNT'(1) << clr_addr_i) : '0;
    // Set is applied after clear so a same-cycle reallocation of rd stays pending.
    pending_d = (pending_q & ~clr_mask) | set_mask;
`ifdef ISSUE_WB_BYPASS_EN
    lookup    = pending_q & ~clr_mask;
`else
    lookup    = pending_q;
`endif
    hazard_o  = valid_i & (lookup[rs1_i] | (use_rs2_i & lookup[rs2_i]) | (chk_rd_i & lookup[rd_i]));
    pending_o = pending_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pending_q <= '0;
    else       pending_q <= pending_d;
  end

endmodule

// File: rtl/issue_ctrl.sv
// Scoreboard-based issue controller: issue register, hazard/limit stalls, flush drain, stall counter.
// Build option ISSUE_WB_BYPASS_EN (in issue_scoreboard) enables same-cycle writeback bypass.
module issue_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  issue_ctrl_if.slave      bus,
  input  logic             wb_valid_i,
  input  reg_addr_t        wb_rd_addr_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);

  issue_state_t         state_q, state_d;
  issue_op_t            ex_q;
  logic                 ex_valid_q;
  logic [INF_W-1:0]     inflight_q, inflight_d;
  logic [CNT_W-1:0]     stall_q;
  logic [REG_COUNT-1:0] pending;
  logic                 hazard, tracked, full, ready, accept, wb_ok;

  assign tracked = is_tracked(bus.dec_reg_write_i, bus.dec_rd_addr_i);
  assign full    = (inflight_q == INF_W'(MAX_INFLIGHT));
  // Stray writebacks (not pending, or nothing outstanding) are dropped.
  assign wb_ok   = wb_valid_i & pending[wb_rd_addr_i] & (inflight_q != '0);

  issue_scoreboard u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_en_i   (accept & tracked),
    .set_addr_i (bus.dec_rd_addr_i),
    .clr_en_i   (wb_ok),
    .clr_addr_i (wb_rd_addr_i),
    .valid_i    (bus.dec_valid_i),
    .rs1_i      (bus.dec_rs1_addr_i),
    .rs2_i      (bus.dec_rs2_addr_i),
    .rd_i       (bus.dec_rd_addr_i),
    .use_rs2_i  (~bus.dec_alu_src_i),
    .chk_rd_i   (tracked),
    .hazard_o   (hazard),
    .pending_o  (pending)
  );

  always_comb begin
    ready  = ~rst_i & ~flush_i & (state_q != ISSUE_DRAIN) & ~hazard &
             (~ex_valid_q | bus.ex_ready_i) & ~(tracked & full);
    accept = bus.dec_valid_i & ready;

    inflight_d = inflight_q;
    unique case ({accept & tracked, wb_ok})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    state_d = state_q;
    if (flush_i) begin
      state_d = ISSUE_DRAIN;
    end else begin
      unique case (state_q)
        ISSUE_RUN:    if (hazard) state_d = ISSUE_HAZARD;
        ISSUE_HAZARD: if (!hazard) state_d = ISSUE_RUN;
        ISSUE_DRAIN:  if (inflight_q == '0 && !wb_valid_i) state_d = ISSUE_RUN;
        default:      state_d = ISSUE_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ISSUE_RUN;
      inflight_q <= '0;
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      if (flush_i) begin
        ex_valid_q <= 1'b0;
      end else if (accept) begin
        ex_valid_q <= 1'b1;
        ex_q       <= '{rs1: bus.dec_rs1_addr_i, rs2: bus.dec_rs2_addr_i,
                        rd: bus.dec_rd_addr_i, reg_write: bus.dec_reg_write_i,
                        alu_src: bus.dec_alu_src_i, alu_op: bus.dec_alu_op_i,
                        imm: bus.dec_imm_i};
      end else if (bus.ex_ready_i) begin
        ex_valid_q <= 1'b0;
      end
      if (bus.dec_valid_i && !ready && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && wb_valid_i) assert (wb_ok);
  end

  assign bus.dec_ready_o    = ready;
  assign bus.ex_valid_o     = ex_valid_q;
  assign bus.ex_rs1_addr_o  = ex_q.rs1;
  assign bus.ex_rs2_addr_o  = ex_q.rs2;
  assign bus.ex_rd_addr_o   = ex_q.rd;
  assign bus.ex_reg_write_o = ex_q.reg_write;
  assign bus.ex_alu_src_o   = ex_q.alu_src;
  assign bus.ex_alu_op_o    = ex_q.alu_op;
  assign bus.ex_imm_o       = ex_q.imm;
  assign stall_cnt_o        = stall_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl: hazards, inflight limit, backpressure, flush, reset.
module tb_issue_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  reg_addr_t   wb_rd;
  logic        flush;
  logic [31:0] stall_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  issue_ctrl_if bus ();

  issue_ctrl #(.MAX_INFLIGHT(4), .CNT_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .wb_valid_i   (wb_valid),
    .wb_rd_addr_i (wb_rd),
    .flush_i      (flush),
    .stall_cnt_o  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input int rs1, input int rs2, input int rd, input logic rw,
                        input logic src, input logic [63:0] imm);
    bus.dec_valid_i     = 1'b1;
    bus.dec_rs1_addr_i  = reg_addr_t'(rs1);
    bus.dec_rs2_addr_i  = reg_addr_t'(rs2);
    bus.dec_rd_addr_i   = reg_addr_t'(rd);
    bus.dec_reg_write_i = rw;
    bus.dec_alu_src_i   = src;
    bus.dec_alu_op_i    = ALU_ADD;
    bus.dec_imm_i       = imm;
  endtask

  task automatic idle();
    bus.dec_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
    bus.ex_ready_i = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state; ready must be low during the reset cycle even with a clean op offered
    rst = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0; bus.ex_ready_i = 1'b1;
    set_op(0, 0, 3, 1'b1, 1'b1, 64'h5);
    settle();
    chk("rst_ready", 64'(bus.dec_ready_o), 64'd0);
    tick();
    chk("rst_ex_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("rst_ex_rd", 64'(bus.ex_rd_addr_o), 64'd0);
    chk("rst_ex_imm", bus.ex_imm_o, 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    idle();
    rst = 1'b0;

    // RAW: add x6,x5,x1 waits for wb of x5
    do_reset();
    set_op(0, 0, 5, 1'b1, 1'b1, 64'h3);
    settle();
    chk("t1_accept_x5", 64'(bus.dec_ready_o), 64'd1);
    tick();
    chk("t1_ex_valid", 64'(bus.ex_valid_o), 64'd1);
    chk("t1_ex_rd", 64'(bus.ex_rd_addr_o), 64'd5);
    chk("t1_ex_imm", bus.ex_imm_o, 64'h3);
    set_op(5, 1, 6, 1'b1, 1'b0, 64'h66);
    bus.dec_alu_op_i = ALU_SUB;
    settle();
    chk("t1_raw_stall0", 64'(bus.dec_ready_o), 64'd0);
    tick();
    settle();
    chk("t1_raw_stall1", 64'(bus.dec_ready_o), 64'd0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd5;
    settle();
`ifdef ISSUE_WB_BYPASS_EN
    chk("t1_bypass_accept", 64'(bus.dec_ready_o), 64'd1);
    tick();
    wb_valid = 1'b0;
`else
    chk("t1_wb_cycle", 64'(bus.dec_ready_o), 64'd0);
    tick();
    wb_valid = 1'b0;
    settle();
    chk("t1_after_wb", 64'(bus.dec_ready_o), 64'd1);
    tick();
`endif
    idle();
    chk("t1_ex_rd6", 64'(bus.ex_rd_addr_o), 64'd6);
    chk("t1_ex_op", 64'(bus.ex_alu_op_o), 64'(ALU_SUB));
`ifdef ISSUE_WB_BYPASS_EN
    chk("t1_stall", 64'(stall_cnt), 64'd2);
`else
    chk("t1_stall", 64'(stall_cnt), 64'd3);
`endif
    tick();
    chk("t1_consumed", 64'(bus.ex_valid_o), 64'd0);

    // Immediate form ignores rs2; WAW on rd still stalls
    do_reset();
    set_op(0, 0, 5, 1'b1, 1'b1, 64'h1);
    settle();
    tick();
    set_op(0, 5, 7, 1'b1, 1'b0, 64'h7);
    settle();
    chk("t2_rs2_hazard", 64'(bus.dec_ready_o), 64'd0);
    bus.dec_alu_src_i = 1'b1;
    settle();
    chk("t2_imm_ok", 64'(bus.dec_ready_o), 64'd1);
    bus.dec_rd_addr_i = 5'd5;
    settle();
    chk("t2_waw", 64'(bus.dec_ready_o), 64'd0);
    bus.dec_rd_addr_i = 5'd7;
    settle();
    tick();
    idle();
    chk("t2_ex_rd", 64'(bus.ex_rd_addr_o), 64'd7);
    chk("t2_ex_rs2", 64'(bus.ex_rs2_addr_o), 64'd5);
    chk("t2_stall", 64'(stall_cnt), 64'd0);

    // Inflight limit: x1..x4 outstanding, 5th tracked op blocks, rd=x0 op passes
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_op(0, 0, i, 1'b1, 1'b1, 64'(i));
      settle();
      chk("t3_fill", 64'(bus.dec_ready_o), 64'd1);
      tick();
    end
    set_op(0, 0, 8, 1'b1, 1'b1, 64'h8);
    settle();
    chk("t3_full", 64'(bus.dec_ready_o), 64'd0);
    bus.dec_rd_addr_i = 5'd0;
    settle();
    chk("t3_x0_ok", 64'(bus.dec_ready_o), 64'd1);
    tick();
    bus.dec_rd_addr_i = 5'd8;
    settle();
    chk("t3_full_again", 64'(bus.dec_ready_o), 64'd0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd2;
    settle();
    chk("t3_wb_cycle", 64'(bus.dec_ready_o), 64'd0);
    tick();
    wb_valid = 1'b0;
    settle();
    chk("t3_released", 64'(bus.dec_ready_o), 64'd1);
    tick();
    idle();
    chk("t3_ex_rd", 64'(bus.ex_rd_addr_o), 64'd8);
    chk("t3_stall", 64'(stall_cnt), 64'd2);

    // Execute backpressure for 5 cycles
    do_reset();
    bus.ex_ready_i = 1'b0;
    set_op(0, 0, 10, 1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567);
    settle();
    chk("t4_first", 64'(bus.dec_ready_o), 64'd1);
    tick();
    set_op(0, 0, 11, 1'b1, 1'b1, 64'h11);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t4_bp_ready", 64'(bus.dec_ready_o), 64'd0);
      chk("t4_bp_rd", 64'(bus.ex_rd_addr_o), 64'd10);
      chk("t4_bp_imm", bus.ex_imm_o, 64'hDEAD_BEEF_0123_4567);
      tick();
    end
    chk("t4_stall", 64'(stall_cnt), 64'd5);
    chk("t4_held", 64'(bus.ex_valid_o), 64'd1);
    bus.ex_ready_i = 1'b1;
    settle();
    chk("t4_release", 64'(bus.dec_ready_o), 64'd1);
    tick();
    idle();
    chk("t4_ex_rd", 64'(bus.ex_rd_addr_o), 64'd11);
    chk("t4_ex_imm", bus.ex_imm_o, 64'h11);
    tick();
    chk("t4_consumed", 64'(bus.ex_valid_o), 64'd0);

    // Flush with nothing in flight: one DRAIN cycle
    do_reset();
    flush = 1'b1;
    settle();
    tick();
    flush = 1'b0;
    set_op(0, 0, 3, 1'b1, 1'b1, 64'h3);
    settle();
    chk("t5a_drain", 64'(bus.dec_ready_o), 64'd0);
    tick();
    settle();
    chk("t5a_run", 64'(bus.dec_ready_o), 64'd1);
    tick();
    idle();

    // Flush with two in flight: drain until both writebacks land
    do_reset();
    set_op(0, 0, 1, 1'b1, 1'b1, 64'h1);
    settle();
    tick();
    set_op(0, 0, 2, 1'b1, 1'b1, 64'h2);
    settle();
    tick();
    bus.ex_ready_i = 1'b0;
    set_op(0, 0, 3, 1'b1, 1'b1, 64'h33);
    flush = 1'b1;
    settle();
    chk("t5b_flush_cycle", 64'(bus.dec_ready_o), 64'd0);
    tick();
    flush = 1'b0;
    bus.ex_ready_i = 1'b1;
    chk("t5b_ex_dropped", 64'(bus.ex_valid_o), 64'd0);
    settle();
    chk("t5b_drain0", 64'(bus.dec_ready_o), 64'd0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd1;
    settle();
    chk("t5b_wb1", 64'(bus.dec_ready_o), 64'd0);
    tick();
    wb_valid = 1'b0;
    settle();
    chk("t5b_drain1", 64'(bus.dec_ready_o), 64'd0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd2;
    settle();
    chk("t5b_wb2", 64'(bus.dec_ready_o), 64'd0);
    tick();
    wb_valid = 1'b0;
    settle();
    chk("t5b_drain_tail", 64'(bus.dec_ready_o), 64'd0);
    tick();
    settle();
    chk("t5b_run", 64'(bus.dec_ready_o), 64'd1);
    tick();
    idle();
    chk("t5b_ex_valid", 64'(bus.ex_valid_o), 64'd1);
    chk("t5b_ex_rd", 64'(bus.ex_rd_addr_o), 64'd3);
    chk("t5b_stall", 64'(stall_cnt), 64'd6);

    // x9 reallocated against its own writeback, then reset mid-stall
    do_reset();
    set_op(0, 0, 9, 1'b1, 1'b1, 64'h9);
    settle();
    tick();
    set_op(0, 0, 9, 1'b1, 1'b1, 64'h99);
    wb_valid = 1'b1; wb_rd = 5'd9;
    settle();
`ifdef ISSUE_WB_BYPASS_EN
    chk("t6_same_cycle", 64'(bus.dec_ready_o), 64'd1);
    tick();
    wb_valid = 1'b0;
`else
    chk("t6_same_cycle", 64'(bus.dec_ready_o), 64'd0);
    tick();
    wb_valid = 1'b0;
    settle();
    chk("t6_next_cycle", 64'(bus.dec_ready_o), 64'd1);
    tick();
`endif
    chk("t6_ex_imm", bus.ex_imm_o, 64'h99);
    set_op(9, 0, 12, 1'b1, 1'b1, 64'h12);
    settle();
    chk("t6_pending9", 64'(bus.dec_ready_o), 64'd0);
    tick();
    settle();
    chk("t6_pending9_b", 64'(bus.dec_ready_o), 64'd0);
    tick();
`ifdef ISSUE_WB_BYPASS_EN
    chk("t6_stall", 64'(stall_cnt), 64'd2);
`else
    chk("t6_stall", 64'(stall_cnt), 64'd3);
`endif
    rst = 1'b1;
    settle();
    chk("t6_rst_ready", 64'(bus.dec_ready_o), 64'd0);
    tick();
    chk("t6_rst_ex_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("t6_rst_ex_rd", 64'(bus.ex_rd_addr_o), 64'd0);
    chk("t6_rst_ex_imm", bus.ex_imm_o, 64'd0);
    chk("t6_rst_ex_rw", 64'(bus.ex_reg_write_o), 64'd0);
    chk("t6_rst_stall", 64'(stall_cnt), 64'd0);
    rst = 1'b0;
    settle();
    chk("t6_post_reset", 64'(bus.dec_ready_o), 64'd1);
    tick();
    idle();
    chk("t6_post_ex_rd", 64'(bus.ex_rd_addr_o), 64'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
